// File: rtl/move_request_gen.sv
// Move request generator: debounces the four push-buttons, runs the gravity timer and
// hands the game-logic FSM one request at a time (checkBoard plus one direction line).
`timescale 1ns/1ps
module move_request_gen #(
    parameter int GRAVITY_TICKS   = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int CNT_W           = 25
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       KEY_left,
    input  logic       KEY_right,
    input  logic       KEY_down,
    input  logic       KEY_drop,
    input  logic       doneLogic,
    input  logic       finishedDrawing,
    output logic       checkBoard,
    output logic       LeftBlock,
    output logic       RightBlock,
    output logic       DownBlock,
    output logic       DropBlock,
    output logic [3:0] pendMask
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAVITY_TICKS - 1);
    localparam int B_DOWN  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_LEFT  = 2;
    localparam int B_DROP  = 3;

    typedef enum logic [1:0] {DIR_DROP, DIR_LEFT, DIR_RIGHT, DIR_DOWN} dir_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE} state_t;

    logic [3:0]       keys;
    logic [3:0]       sync_a;
    logic [3:0]       sync_b;
    logic [3:0]       level;
    logic [3:0]       press;
    logic [CNT_W-1:0] db_cnt [4];
    logic [CNT_W-1:0] grav_cnt;
    logic             grav_tick;
    logic             drop_p, left_p, right_p, down_p, grav_p;
    logic             drop_n, left_n, right_n, down_n, grav_n;
    logic             any_pend;
    logic             issue;
    logic             clr_down;
    dir_t             win;
    dir_t             dir_q;
    state_t           state;
    logic [3:0]       lines;

    function automatic logic [3:0] dir_lines(input dir_t d);
        logic [3:0] l;
        unique case (d)
            DIR_DROP:  l = 4'b1000;
            DIR_LEFT:  l = 4'b0100;
            DIR_RIGHT: l = 4'b0010;
            DIR_DOWN:  l = 4'b0001;
        endcase
        return l;
    endfunction

    assign keys = {KEY_drop, KEY_left, KEY_right, KEY_down};

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            sync_a <= 4'b1111;
            sync_b <= 4'b1111;
        end else begin
            sync_a <= keys;
            sync_b <= sync_a;
        end
    end

    // level is active-low like the keys: 1 = released
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            level <= 4'b1111;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    level[i]  <= ~level[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        press = '0;
        for (int i = 0; i < 4; i++)
            press[i] = level[i] & ~sync_b[i] & (db_cnt[i] == DB_LAST);
    end

    assign grav_tick = (grav_cnt == GRAV_LAST);
    assign any_pend  = drop_p | left_p | right_p | down_p | grav_p;
    assign issue     = (state == S_IDLE) & any_pend & finishedDrawing;

    always_comb begin
        if (drop_p)       win = DIR_DROP;
        else if (left_p)  win = DIR_LEFT;
        else if (right_p) win = DIR_RIGHT;
        else              win = DIR_DOWN;
    end

    // a new press or tick in the same cycle as a clear keeps its pend bit
    assign clr_down = issue & (win == DIR_DOWN);
    assign drop_n   = press[B_DROP]  | (drop_p  & ~(issue & (win == DIR_DROP)));
    assign left_n   = press[B_LEFT]  | (left_p  & ~(issue & (win == DIR_LEFT)));
    assign right_n  = press[B_RIGHT] | (right_p & ~(issue & (win == DIR_RIGHT)));
    assign down_n   = press[B_DOWN]  | (down_p  & ~clr_down);
    assign grav_n   = grav_tick      | (grav_p  & ~clr_down);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            grav_cnt <= '0;
        end else if (issue && (win == DIR_DOWN || win == DIR_DROP)) begin
            grav_cnt <= '0;
        end else if (grav_tick) begin
            grav_cnt <= '0;
        end else begin
            grav_cnt <= grav_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            drop_p   <= 1'b0;
            left_p   <= 1'b0;
            right_p  <= 1'b0;
            down_p   <= 1'b0;
            grav_p   <= 1'b0;
            pendMask <= 4'b0000;
        end else begin
            drop_p   <= drop_n;
            left_p   <= left_n;
            right_p  <= right_n;
            down_p   <= down_n;
            grav_p   <= grav_n;
            pendMask <= {drop_n, left_n, right_n, down_n | grav_n};
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state      <= S_IDLE;
            dir_q      <= DIR_DOWN;
            checkBoard <= 1'b0;
            lines      <= 4'b0000;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (issue) begin
                        state      <= S_ISSUE;
                        dir_q      <= win;
                        checkBoard <= 1'b1;
                        lines      <= dir_lines(win);
                    end
                end
                S_ISSUE: begin
                    if (doneLogic) begin
                        state      <= S_RELEASE;
                        checkBoard <= 1'b0;
                        lines      <= 4'b0000;
                    end else begin
                        checkBoard <= 1'b1;
                        lines      <= dir_lines(dir_q);
                    end
                end
                S_RELEASE: begin
                    state      <= S_IDLE;
                    checkBoard <= 1'b0;
                    lines      <= 4'b0000;
                end
                default: begin
                    state      <= S_IDLE;
                    checkBoard <= 1'b0;
                    lines      <= 4'b0000;
                end
            endcase
        end
    end

    assign DropBlock  = lines[3];
    assign LeftBlock  = lines[2];
    assign RightBlock = lines[1];
    assign DownBlock  = lines[0];

endmodule

// File: tb/tb_move_request_gen.sv
// Directed bench for move_request_gen: a per-cycle vector table for the basic left press
// plus hand-written sequences for glitches, gravity, priority, long waits and async reset.
`timescale 1ns/1ps
module tb_move_request_gen;

    localparam int GT = 16;
    localparam int DB = 4;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn = 1'b0;
    logic       KEY_left = 1'b1;
    logic       KEY_right = 1'b1;
    logic       KEY_down = 1'b1;
    logic       KEY_drop = 1'b1;
    logic       doneLogic;
    logic       finishedDrawing = 1'b0;
    logic       checkBoard, LeftBlock, RightBlock, DownBlock, DropBlock;
    logic [3:0] pendMask;

    logic man_done = 1'b0;
    logic resp_done = 1'b0;
    logic auto_done = 1'b0;
    int   resp_delay = 3;
    int   resp_cnt = 0;

    assign doneLogic = man_done | resp_done;

    move_request_gen #(
        .GRAVITY_TICKS(GT),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(8)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .Resetn(Resetn),
        .KEY_left(KEY_left),
        .KEY_right(KEY_right),
        .KEY_down(KEY_down),
        .KEY_drop(KEY_drop),
        .doneLogic(doneLogic),
        .finishedDrawing(finishedDrawing),
        .checkBoard(checkBoard),
        .LeftBlock(LeftBlock),
        .RightBlock(RightBlock),
        .DownBlock(DownBlock),
        .DropBlock(DropBlock),
        .pendMask(pendMask)
    );

    initial forever #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;

    // cycle monitor: edge count since reset, rising edges per line, protocol violations
    int         cyc, viol, n_left, n_right, n_down, n_drop;
    int         down_t[$];
    logic [3:0] prev_d, mon_d;

    always @(negedge CLOCK_50) begin
        mon_d = {DropBlock, LeftBlock, RightBlock, DownBlock};
        if (!Resetn) begin
            cyc = 0; viol = 0;
            n_left = 0; n_right = 0; n_down = 0; n_drop = 0;
            down_t.delete();
            prev_d = 4'b0000;
        end else begin
            cyc++;
            if (checkBoard ? !$onehot(mon_d) : (mon_d != 4'b0000)) viol++;
            if (mon_d[3] && !prev_d[3]) n_drop++;
            if (mon_d[2] && !prev_d[2]) n_left++;
            if (mon_d[1] && !prev_d[1]) n_right++;
            if (mon_d[0] && !prev_d[0]) begin
                n_down++;
                down_t.push_back(cyc);
            end
            prev_d = mon_d;
        end
    end

    // automatic FSM stand-in: doneLogic high in the resp_delay-th request cycle
    always @(negedge CLOCK_50) begin
        if (!Resetn || !auto_done || !checkBoard || resp_done) begin
            resp_done = 1'b0;
            resp_cnt  = 0;
        end else if (resp_cnt == resp_delay - 1) begin
            resp_done = 1'b1;
        end else begin
            resp_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        man_done = 1'b0;
        KEY_left = 1'b1; KEY_right = 1'b1; KEY_down = 1'b1; KEY_drop = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        #2 Resetn = 1'b1;
    endtask

    task automatic chk_out(input string name, input logic c,
                           input logic [3:0] l, input logic [3:0] m);
        logic [8:0] act, exp;
        act = {checkBoard, DropBlock, LeftBlock, RightBlock, DownBlock, pendMask};
        exp = {c, l, m};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {chk,drop,left,right,down,mask} got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       key;
        logic       done;
        logic       c;
        logic [3:0] l;
        logic [3:0] m;
    } vec_t;

    vec_t tv [14];
    logic stable;

    initial begin
        // left press: 2 sync + 4 debounce edges set the pend bit, one more issues
        tv[0]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tv[2]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tv[3]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tv[4]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tv[5]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000};
        tv[7]  = '{1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000};
        tv[10] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tv[11] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tv[12] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tv[13] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};

        // 1: basic left press, single request while held
        finishedDrawing = 1'b1;
        auto_done = 1'b0;
        do_reset();
        chk_out("reset_state", 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 14; i++) begin
            KEY_left = tv[i].key;
            man_done = tv[i].done;
            tick();
            chk_out($sformatf("t1_vec%0d", i), tv[i].c, tv[i].l, tv[i].m);
        end
        man_done = 1'b0;
        chk_int("t1_left_count", n_left, 1);
        chk_int("t1_invariant", viol, 0);

        // 2: short glitches on right never debounce
        auto_done = 1'b1;
        do_reset();
        for (int r = 0; r < 5; r++) begin
            KEY_right = 1'b0;
            repeat (3) tick();
            KEY_right = 1'b1;
            tick();
        end
        repeat (10) tick();
        chk_int("t2_right_count", n_right, 0);
        chk_int("t2_right_pend", int'(pendMask[1]), 0);
        chk_int("t2_invariant", viol, 0);

        // 3: gravity alone; tick sets pend, issue one edge later restarts the timer
        do_reset();
        repeat (75) tick();
        chk_int("t3_down_count", down_t.size(), 4);
        if (down_t.size() > 0) chk_int("t3_first_down", down_t[0], GT + 1);
        for (int i = 1; i < down_t.size(); i++)
            chk_int($sformatf("t3_spacing%0d", i), down_t[i] - down_t[i-1], GT + 1);
        chk_int("t3_drop_count", n_drop, 0);
        chk_int("t3_invariant", viol, 0);

        // 4: drop and left debounced together, drop wins
        auto_done = 1'b0;
        do_reset();
        KEY_drop = 1'b0;
        KEY_left = 1'b0;
        repeat (6) tick();
        chk_out("t4_both_pend", 1'b0, 4'b0000, 4'b1100);
        tick();
        chk_out("t4_drop_issue", 1'b1, 4'b1000, 4'b0100);
        repeat (2) tick();
        chk_out("t4_drop_hold", 1'b1, 4'b1000, 4'b0100);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk_out("t4_release", 1'b0, 4'b0000, 4'b0100);
        tick();
        chk_out("t4_idle", 1'b0, 4'b0000, 4'b0100);
        tick();
        chk_out("t4_left_issue", 1'b1, 4'b0100, 4'b0000);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk_int("t4_invariant", viol, 0);

        // 5: long outstanding request, right queued, finishedDrawing gating
        do_reset();
        KEY_left = 1'b0;
        repeat (7) tick();
        stable = (checkBoard === 1'b1) &&
                 ({DropBlock, LeftBlock, RightBlock, DownBlock} === 4'b0100);
        for (int k = 8; k <= 107; k++) begin
            tick();
            if (k == 12) KEY_left = 1'b1;
            if (k == 20) KEY_right = 1'b0;
            if (checkBoard !== 1'b1 ||
                {DropBlock, LeftBlock, RightBlock, DownBlock} !== 4'b0100)
                stable = 1'b0;
        end
        chk_int("t5_stable", int'(stable), 1);
        chk_out("t5_queued", 1'b1, 4'b0100, 4'b0011);
        man_done = 1'b1;
        finishedDrawing = 1'b0;
        tick();
        man_done = 1'b0;
        chk_out("t5_release", 1'b0, 4'b0000, 4'b0011);
        repeat (6) tick();
        chk_out("t5_held_back", 1'b0, 4'b0000, 4'b0011);
        finishedDrawing = 1'b1;
        tick();
        chk_out("t5_right_issue", 1'b1, 4'b0010, 4'b0001);
        chk_int("t5_invariant", viol, 0);

        // 6: asynchronous reset in the middle of a request
        do_reset();
        KEY_left = 1'b0;
        KEY_right = 1'b0;
        repeat (7) tick();
        chk_out("t6_issue", 1'b1, 4'b0100, 4'b0010);
        #2 Resetn = 1'b0;
        #1 chk_out("t6_async_reset", 1'b0, 4'b0000, 4'b0000);
        KEY_left = 1'b1;
        KEY_right = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        #2 Resetn = 1'b1;
        repeat (4) tick();
        chk_out("t6_idle_after", 1'b0, 4'b0000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
